// File: rtl/aes_pkg.sv
// Shared constants and types for the AES round controller.
// Stage indices match the bit order of the stage_* buses.
package aes_pkg;

    localparam logic [1:0] STG_SUB   = 2'd0;
    localparam logic [1:0] STG_SROWS = 2'd1;
    localparam logic [1:0] STG_MIX   = 2'd2;
    localparam logic [1:0] STG_ARK   = 2'd3;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 128;
    localparam int NUM_W  = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        NEXT  = 3'd3,
        DONE  = 3'd4,
        ERROR = 3'd5
    } state_t;

    function automatic logic [3:0] stage_onehot(input logic [1:0] stg);
        return 4'b0001 << stg;
    endfunction

endpackage

// File: rtl/aes_sram_mux.sv
// Combinational 4:1 mux of the stage SRAM buses; all outputs are zero
// whenever no stage holds the grant.
module aes_sram_mux
    import aes_pkg::*;
(
    input  logic                  i_grant_valid,
    input  logic [1:0]            i_sel,
    input  logic [3:0]            i_read,
    input  logic [3:0]            i_write,
    input  logic [3:0]            i_dump,
    input  logic [3:0]            i_init,
    input  logic [4*ADDR_W-1:0]   i_addr,
    input  logic [4*NUM_W-1:0]    i_dump_num,
    input  logic [4*NUM_W-1:0]    i_init_num,
    input  logic [4*DATA_W-1:0]   i_wdata,
    output logic                  o_read,
    output logic                  o_write,
    output logic                  o_dump,
    output logic                  o_init,
    output logic [ADDR_W-1:0]     o_addr,
    output logic [NUM_W-1:0]      o_dump_num,
    output logic [NUM_W-1:0]      o_init_num,
    output logic [DATA_W-1:0]     o_wdata
);

    // Select the granted stage's fields or drive all zeros.
    always_comb begin
        o_read     = 1'b0;
        o_write    = 1'b0;
        o_dump     = 1'b0;
        o_init     = 1'b0;
        o_addr     = {ADDR_W{1'b0}};
        o_dump_num = {NUM_W{1'b0}};
        o_init_num = {NUM_W{1'b0}};
        o_wdata    = {DATA_W{1'b0}};
        if (i_grant_valid) begin
            o_read     = i_read[i_sel];
            o_write    = i_write[i_sel];
            o_dump     = i_dump[i_sel];
            o_init     = i_init[i_sel];
            o_addr     = i_addr[i_sel*ADDR_W +: ADDR_W];
            o_dump_num = i_dump_num[i_sel*NUM_W +: NUM_W];
            o_init_num = i_init_num[i_sel*NUM_W +: NUM_W];
            o_wdata    = i_wdata[i_sel*DATA_W +: DATA_W];
        end else begin
            o_read = 1'b0;
        end
    end

endmodule

// File: rtl/aes_round_ctrl.sv
// Sequences the AES stage blocks through the cipher schedule, times out
// stalled stages and routes the running stage onto the shared SRAM port.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = 10,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [3:0]            round,
    output logic [3:0]            stage_enable,
    input  logic [3:0]            stage_finished,
    input  logic [3:0]            stage_sramRead,
    input  logic [3:0]            stage_sramWrite,
    input  logic [3:0]            stage_sramDump,
    input  logic [3:0]            stage_sramInit,
    input  logic [4*ADDR_W-1:0]   stage_sramAddr,
    input  logic [4*NUM_W-1:0]    stage_sramDumpNum,
    input  logic [4*NUM_W-1:0]    stage_sramInitNum,
    input  logic [4*DATA_W-1:0]   stage_sramWriteValue,
    output logic                  sramRead,
    output logic                  sramWrite,
    output logic                  sramDump,
    output logic                  sramInit,
    output logic [ADDR_W-1:0]     sramAddr,
    output logic [NUM_W-1:0]      sramDumpNum,
    output logic [NUM_W-1:0]      sramInitNum,
    output logic [DATA_W-1:0]     sramWriteValue
);

    localparam int          TMR_W      = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [3:0]  LAST_ROUND = 4'(NUM_ROUNDS);

    state_t           r_state;
    logic [3:0]       r_round;
    logic [1:0]       r_cur_stage;
    logic [TMR_W-1:0] r_timer;
    logic             r_busy;
    logic             r_done;
    logic             r_error;
    logic [3:0]       r_stage_enable;

    state_t           w_next_state;
    logic [3:0]       w_next_round;
    logic [1:0]       w_next_stage;
    logic [TMR_W-1:0] w_next_timer;
    logic             w_grant_valid;

    // Next-state, schedule and timeout decisions.
    always_comb begin
        w_next_state = r_state;
        w_next_round = r_round;
        w_next_stage = r_cur_stage;
        w_next_timer = r_timer;
        case (r_state)
            IDLE, ERROR: begin
                if (start) begin
                    w_next_state = ISSUE;
                    w_next_round = 4'd0;
                    w_next_stage = STG_ARK;
                end else begin
                    w_next_state = r_state;
                end
            end
            ISSUE: begin
                w_next_timer = {TMR_W{1'b0}};
                w_next_state = WAIT;
            end
            WAIT: begin
                w_next_timer = r_timer + {{(TMR_W-1){1'b0}}, 1'b1};
                if (stage_finished[r_cur_stage]) begin
                    w_next_state = NEXT;
                end else if (r_timer == TMR_LAST) begin
                    w_next_state = ERROR;
                end else begin
                    w_next_state = WAIT;
                end
            end
            NEXT: begin
                w_next_state = ISSUE;
                case (r_cur_stage)
                    STG_SUB:   w_next_stage = STG_SROWS;
                    STG_SROWS: begin
                        if (r_round == LAST_ROUND) begin
                            w_next_stage = STG_ARK;
                        end else begin
                            w_next_stage = STG_MIX;
                        end
                    end
                    STG_MIX:   w_next_stage = STG_ARK;
                    default: begin
                        if (r_round == LAST_ROUND) begin
                            w_next_state = DONE;
                        end else begin
                            w_next_round = r_round + 4'd1;
                            w_next_stage = STG_SUB;
                        end
                    end
                endcase
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // State registers; status outputs are registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_round        <= 4'd0;
            r_cur_stage    <= STG_ARK;
            r_timer        <= {TMR_W{1'b0}};
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
            r_stage_enable <= 4'd0;
        end else begin
            r_state        <= w_next_state;
            r_round        <= w_next_round;
            r_cur_stage    <= w_next_stage;
            r_timer        <= w_next_timer;
            r_busy         <= (w_next_state == ISSUE) || (w_next_state == WAIT) ||
                              (w_next_state == NEXT);
            r_done         <= (w_next_state == DONE);
            r_error        <= (w_next_state == ERROR);
            r_stage_enable <= (w_next_state == ISSUE) ? stage_onehot(w_next_stage) : 4'd0;
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign error         = r_error;
    assign round         = r_round;
    assign stage_enable  = r_stage_enable;
    assign w_grant_valid = (r_state == ISSUE) || (r_state == WAIT);

    aes_sram_mux u_sram_mux (
        .i_grant_valid (w_grant_valid),
        .i_sel         (r_cur_stage),
        .i_read        (stage_sramRead),
        .i_write       (stage_sramWrite),
        .i_dump        (stage_sramDump),
        .i_init        (stage_sramInit),
        .i_addr        (stage_sramAddr),
        .i_dump_num    (stage_sramDumpNum),
        .i_init_num    (stage_sramInitNum),
        .i_wdata       (stage_sramWriteValue),
        .o_read        (sramRead),
        .o_write       (sramWrite),
        .o_dump        (sramDump),
        .o_init        (sramInit),
        .o_addr        (sramAddr),
        .o_dump_num    (sramDumpNum),
        .o_init_num    (sramInitNum),
        .o_wdata       (sramWriteValue)
    );

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl with simple stage models that finish
// a programmable number of cycles after their enable pulse.
module tb_aes_round_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         busy, done, error;
    logic [3:0]   round, stage_enable, stage_finished;
    logic [3:0]   stage_sramRead, stage_sramWrite, stage_sramDump, stage_sramInit;
    logic [63:0]  stage_sramAddr;
    logic [11:0]  stage_sramDumpNum, stage_sramInitNum;
    logic [511:0] stage_sramWriteValue;
    logic         sramRead, sramWrite, sramDump, sramInit;
    logic [15:0]  sramAddr;
    logic [2:0]   sramDumpNum, sramInitNum;
    logic [127:0] sramWriteValue;

    logic [3:0]   model_fin = 4'd0;
    logic [3:0]   spur = 4'd0;
    logic [3:0]   mask = 4'd0;
    int           fin_delay [4];
    int           cnt [4];
    bit           run [4];
    logic [3:0]   en_log [$];
    logic [3:0]   exp_seq [40];
    int           done_cnt = 0;
    int           n_chk = 0;
    int           n_pass = 0;
    logic         sram_any;

    always #5 clk = ~clk;

    assign stage_finished = model_fin | spur;
    assign sram_any = sramRead | sramWrite | sramDump | sramInit | (|sramAddr) |
                      (|sramDumpNum) | (|sramInitNum) | (|sramWriteValue);

    aes_round_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
        .round(round), .stage_enable(stage_enable), .stage_finished(stage_finished),
        .stage_sramRead(stage_sramRead), .stage_sramWrite(stage_sramWrite),
        .stage_sramDump(stage_sramDump), .stage_sramInit(stage_sramInit),
        .stage_sramAddr(stage_sramAddr), .stage_sramDumpNum(stage_sramDumpNum),
        .stage_sramInitNum(stage_sramInitNum), .stage_sramWriteValue(stage_sramWriteValue),
        .sramRead(sramRead), .sramWrite(sramWrite), .sramDump(sramDump), .sramInit(sramInit),
        .sramAddr(sramAddr), .sramDumpNum(sramDumpNum), .sramInitNum(sramInitNum),
        .sramWriteValue(sramWriteValue)
    );

    // Stage models, enable logger and done counter.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            model_fin[i] = 1'b0;
            if (rst) begin
                run[i] = 1'b0;
                cnt[i] = 0;
            end else if (stage_enable[i]) begin
                run[i] = 1'b1;
                cnt[i] = 0;
            end else if (run[i]) begin
                cnt[i] = cnt[i] + 1;
                if (cnt[i] == fin_delay[i]) begin
                    run[i] = 1'b0;
                    if (!mask[i]) model_fin[i] = 1'b1;
                end
            end
        end
        if (stage_enable != 4'd0) en_log.push_back(stage_enable);
        if (done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_start();
        en_log.delete();
        done_cnt = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic pulse_rst();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic wait_en(input int b, input int rnd, input int maxc);
        int n = 0;
        while (!(stage_enable[b] && round == 4'(rnd)) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("wait_en%0d_r%0d", b, rnd), 32'(n < maxc), 32'd1);
    endtask

    task automatic wait_done(input int maxc);
        int n = 0;
        while (!done && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk("wait_done", 32'(n < maxc), 32'd1);
    endtask

    task automatic check_seq(input string tag);
        chk({tag, "_count"}, 32'(en_log.size()), 32'd40);
        for (int i = 0; i < 40 && i < en_log.size(); i++)
            chk($sformatf("%s_en%0d", tag, i), 32'(en_log[i]), 32'(exp_seq[i]));
    endtask

    initial begin
        int k;
        int n;
        rst = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fin_delay[i] = 9;
            run[i] = 1'b0;
            cnt[i] = 0;
            stage_sramAddr[16*i +: 16]       = (i == 1) ? 16'd32 : 16'hFFFF;
            stage_sramRead[i]                = (i == 1);
            stage_sramWrite[i]               = (i != 1);
            stage_sramDump[i]                = (i != 1);
            stage_sramInit[i]                = (i != 1);
            stage_sramDumpNum[3*i +: 3]      = (i == 1) ? 3'd0 : 3'd7;
            stage_sramInitNum[3*i +: 3]      = (i == 1) ? 3'd0 : 3'd7;
            stage_sramWriteValue[128*i +: 128] = (i == 1) ? {128{1'b0}} : {128{1'b1}};
        end
        k = 0;
        exp_seq[k++] = 4'b1000;
        for (int r = 1; r < 10; r++) begin
            exp_seq[k++] = 4'b0001; exp_seq[k++] = 4'b0010;
            exp_seq[k++] = 4'b0100; exp_seq[k++] = 4'b1000;
        end
        exp_seq[k++] = 4'b0001; exp_seq[k++] = 4'b0010; exp_seq[k++] = 4'b1000;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_round", 32'(round), 32'd0);
        chk("rst_enable", 32'(stage_enable), 32'd0);
        chk("idle_sram_zero", 32'(sram_any), 32'd0);

        // Full run with grant isolation checks around the first srows.
        do_start();
        wait_en(1, 1, 200);
        chk("issue_addr", 32'(sramAddr), 32'd32);
        chk("issue_rdwr", 32'({sramRead, sramWrite, sramDump, sramInit}), 32'b1000);
        chk("issue_wdata", 32'(|sramWriteValue), 32'd0);
        @(negedge clk);
        chk("wait_addr", 32'(sramAddr), 32'd32);
        chk("wait_rdwr", 32'({sramRead, sramWrite}), 32'b10);
        n = 0;
        while (!stage_finished[1] && n < 20) begin
            @(posedge clk);
            n++;
        end
        chk("srows_fin_seen", 32'(n < 20), 32'd1);
        @(negedge clk);
        chk("next_sram_zero", 32'(sram_any), 32'd0);
        chk("next_busy", 32'(busy), 32'd1);
        wait_done(2000);
        chk("done_round", 32'(round), 32'd10);
        chk("done_sram_zero", 32'(sram_any), 32'd0);
        @(negedge clk);
        chk("after_busy", 32'(busy), 32'd0);
        chk("after_done", 32'(done), 32'd0);
        repeat (5) @(negedge clk);
        chk("run1_done_cnt", 32'(done_cnt), 32'd1);
        chk("hold_round", 32'(round), 32'd10);
        check_seq("run1");

        // Spurious finished from mix_cols and a start while busy.
        do_start();
        wait_en(1, 1, 200);
        start = 1'b1;
        spur = 4'b0100;
        @(negedge clk);
        start = 1'b0;
        spur = 4'b0000;
        n = 1;
        while (stage_enable == 4'd0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("spur_gap", 32'(n), 32'd11);
        chk("spur_next_en", 32'(stage_enable), 32'b0100);
        chk("spur_round", 32'(round), 32'd1);
        wait_done(2000);
        repeat (3) @(negedge clk);
        chk("run2_count", 32'(en_log.size()), 32'd40);
        chk("run2_done_cnt", 32'(done_cnt), 32'd1);

        // Timeout: sub_bytes never finishes.
        mask = 4'b0001;
        do_start();
        wait_en(0, 1, 200);
        repeat (64) @(negedge clk);
        chk("to_err_early", 32'(error), 32'd0);
        chk("to_busy_early", 32'(busy), 32'd1);
        @(negedge clk);
        chk("to_err", 32'(error), 32'd1);
        chk("to_busy", 32'(busy), 32'd0);
        chk("to_sram_zero", 32'(sram_any), 32'd0);
        en_log.delete();
        repeat (20) @(negedge clk);
        chk("to_no_enable", 32'(en_log.size()), 32'd0);
        chk("to_err_level", 32'(error), 32'd1);
        mask = 4'b0000;
        do_start();
        chk("to_restart_err", 32'(error), 32'd0);
        chk("to_restart_en", 32'(stage_enable), 32'b1000);
        chk("to_restart_round", 32'(round), 32'd0);
        pulse_rst();

        // Finished lands in the same cycle as the last timer count.
        fin_delay[3] = 64;
        do_start();
        repeat (64) @(negedge clk);
        @(negedge clk);
        chk("sim_err", 32'(error), 32'd0);
        chk("sim_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("sim_next_en", 32'(stage_enable), 32'b0001);
        chk("sim_round", 32'(round), 32'd1);
        fin_delay[3] = 9;
        pulse_rst();

        // Reset during round 5 mix_cols, then a clean full run.
        do_start();
        wait_en(2, 5, 1000);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_round", 32'(round), 32'd0);
        chk("mrst_enable", 32'(stage_enable), 32'd0);
        chk("mrst_flags", 32'({done, error}), 32'd0);
        chk("mrst_sram_zero", 32'(sram_any), 32'd0);
        rst = 1'b0;
        do_start();
        wait_done(2000);
        repeat (3) @(negedge clk);
        chk("run3_done_cnt", 32'(done_cnt), 32'd1);
        check_seq("run3");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
